rx_msg_decoder: RTL and testbench

RX_MSG_DECODER -- requirements
Module: rx_msg_decoder

---
 rtl/rx_msg_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_rx_msg_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_msg_decoder.sv
// rtl/rx_msg_decoder.sv - ASCII "{R0500,G0042}" duty message decoder; define RX_DEC_ERR_CNT_EN to add err_count
module rx_msg_decoder #(
  parameter int DUTY_W   = 14,
  parameter int DUTY_MAX = 1000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              clk_enable,
  input  logic [127:0]      valid_messege_out,
  input  logic              valid_message_flag,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic              update_pulse,
  output logic              decode_err,
  output logic              msg_dropped,
`ifdef RX_DEC_ERR_CNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LETTER,
    S_DIGIT,
    S_SEP,
    S_COMMIT,
    S_ERR
  } state_t;

  localparam logic [7:0] CH_R     = 8'h52;
  localparam logic [7:0] CH_G     = 8'h47;
  localparam logic [7:0] CH_B     = 8'h42;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_CLOSE = 8'h7D;

  state_t              state, state_n;
  logic [127:0]        msg_q, msg_n;
  logic [3:0]          idx, idx_n;
  logic [1:0]          chan, chan_n;
  logic [13:0]         acc, acc_n;
  logic [1:0]          dig_cnt, dig_n;
  logic [DUTY_W-1:0]   stg_r, stg_g, stg_b;
  logic [DUTY_W-1:0]   stg_r_n, stg_g_n, stg_b_n;
  logic [2:0]          staged, staged_n;
  logic [DUTY_W-1:0]   duty_r_n, duty_g_n, duty_b_n;
  logic                upd_n, err_n, drop_n;
  logic                flag_q, armed;
  logic                rise;
  logic [7:0]          byte_cur;
  logic                is_digit;
  logic [13:0]         acc_mac;
  logic [13:0]         sat_val;

  // armed stays low until the first enabled cycle after reset so a flag
  // that is already high at reset release is not taken as a new message
  assign rise     = armed && valid_message_flag && !flag_q;
  assign byte_cur = msg_q[{idx, 3'b000} +: 8];
  assign is_digit = (byte_cur >= 8'h30) && (byte_cur <= 8'h39);
  assign acc_mac  = (acc << 3) + (acc << 1) + {10'd0, byte_cur[3:0]};
  assign sat_val  = (acc > 14'(DUTY_MAX)) ? 14'(DUTY_MAX) : acc;
  assign busy     = (state != S_IDLE);

  // state register and datapath, all held while clk_enable is low
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      msg_q        <= '0;
      idx          <= '0;
      chan         <= '0;
      acc          <= '0;
      dig_cnt      <= '0;
      stg_r        <= '0;
      stg_g        <= '0;
      stg_b        <= '0;
      staged       <= '0;
      duty_r       <= '0;
      duty_g       <= '0;
      duty_b       <= '0;
      update_pulse <= 1'b0;
      decode_err   <= 1'b0;
      msg_dropped  <= 1'b0;
      flag_q       <= 1'b0;
      armed        <= 1'b0;
    end else if (clk_enable) begin
      state        <= state_n;
      msg_q        <= msg_n;
      idx          <= idx_n;
      chan         <= chan_n;
      acc          <= acc_n;
      dig_cnt      <= dig_n;
      stg_r        <= stg_r_n;
      stg_g        <= stg_g_n;
      stg_b        <= stg_b_n;
      staged       <= staged_n;
      duty_r       <= duty_r_n;
      duty_g       <= duty_g_n;
      duty_b       <= duty_b_n;
      update_pulse <= upd_n;
      decode_err   <= err_n;
      msg_dropped  <= drop_n;
      flag_q       <= valid_message_flag;
      armed        <= 1'b1;
    end
  end

  // next-state decode: one message byte consumed per enabled cycle
  always_comb begin
    state_n  = state;
    msg_n    = msg_q;
    idx_n    = idx;
    chan_n   = chan;
    acc_n    = acc;
    dig_n    = dig_cnt;
    stg_r_n  = stg_r;
    stg_g_n  = stg_g;
    stg_b_n  = stg_b;
    staged_n = staged;
    duty_r_n = duty_r;
    duty_g_n = duty_g;
    duty_b_n = duty_b;
    upd_n    = 1'b0;
    err_n    = 1'b0;
    drop_n   = rise && (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (rise) begin
          msg_n    = valid_messege_out;
          idx_n    = 4'd14;
          stg_r_n  = '0;
          stg_g_n  = '0;
          stg_b_n  = '0;
          staged_n = '0;
          state_n  = S_LETTER;
        end
      end
      S_LETTER: begin
        idx_n = idx - 4'd1;
        acc_n = '0;
        dig_n = '0;
        if (byte_cur == CH_R) begin
          chan_n  = 2'd0;
          state_n = S_DIGIT;
        end else if (byte_cur == CH_G) begin
          chan_n  = 2'd1;
          state_n = S_DIGIT;
        end else if (byte_cur == CH_B) begin
          chan_n  = 2'd2;
          state_n = S_DIGIT;
        end else begin
          state_n = S_ERR;
        end
      end
      S_DIGIT: begin
        idx_n = idx - 4'd1;
        if (is_digit) begin
          acc_n = acc_mac;
          dig_n = dig_cnt + 2'd1;
          if (dig_cnt == 2'd3) begin
            state_n = S_SEP;
          end
        end else begin
          state_n = S_ERR;
        end
      end
      S_SEP: begin
        idx_n = idx - 4'd1;
        case (chan)
          2'd0:    begin stg_r_n = DUTY_W'(sat_val); staged_n[0] = 1'b1; end
          2'd1:    begin stg_g_n = DUTY_W'(sat_val); staged_n[1] = 1'b1; end
          default: begin stg_b_n = DUTY_W'(sat_val); staged_n[2] = 1'b1; end
        endcase
        if (byte_cur == CH_COMMA) begin
          state_n = S_LETTER;
        end else if (byte_cur == CH_CLOSE) begin
          state_n = S_COMMIT;
        end else begin
          state_n = S_ERR;
        end
      end
      S_COMMIT: begin
        if (staged[0]) duty_r_n = stg_r;
        if (staged[1]) duty_g_n = stg_g;
        if (staged[2]) duty_b_n = stg_b;
        upd_n   = 1'b1;
        state_n = S_IDLE;
      end
      S_ERR: begin
        err_n   = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // byte 0 consumed without reaching "}" means the message ran out
    if ((state == S_LETTER || state == S_DIGIT || state == S_SEP) && idx == 4'd0 &&
        state_n != S_COMMIT && state_n != S_ERR) begin
      state_n = S_ERR;
    end
  end

`ifdef RX_DEC_ERR_CNT_EN
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign err_inc = {1'b0, err_n} + {1'b0, drop_n};
  assign err_sum = {1'b0, err_count} + {7'd0, err_inc};

  // saturating count of rejected and dropped messages
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (clk_enable) begin
      err_count <= err_sum[8] ? 8'd255 : err_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_rx_msg_decoder.sv
// tb/tb_rx_msg_decoder.sv - directed and random message checks against a string-level parser model
module tb_rx_msg_decoder;
  localparam int DUTY_W   = 14;
  localparam int DUTY_MAX = 1000;

  typedef byte unsigned msg_t [16];

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              clk_enable = 1'b0;
  logic [127:0]      valid_messege_out = '0;
  logic              valid_message_flag = 1'b0;
  logic [DUTY_W-1:0] duty_r, duty_g, duty_b;
  logic              update_pulse, decode_err, msg_dropped, busy;
`ifdef RX_DEC_ERR_CNT_EN
  logic [7:0]        err_count;
`endif

  int   checks = 0;
  int   failures = 0;
  int   exp_duty [3];
  int   exp_errs = 0;
  msg_t cur_msg;
  bit   m_ok;
  int   m_cyc;
  int   m_v [3];
  bit [2:0] m_mask;

  always #5 sys_clk = ~sys_clk;

  rx_msg_decoder #(.DUTY_W(DUTY_W), .DUTY_MAX(DUTY_MAX)) dut (
    .sys_clk            (sys_clk),
    .rst                (rst),
    .clk_enable         (clk_enable),
    .valid_messege_out  (valid_messege_out),
    .valid_message_flag (valid_message_flag),
    .duty_r             (duty_r),
    .duty_g             (duty_g),
    .duty_b             (duty_b),
    .update_pulse       (update_pulse),
    .decode_err         (decode_err),
    .msg_dropped        (msg_dropped),
`ifdef RX_DEC_ERR_CNT_EN
    .err_count          (err_count),
`endif
    .busy               (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load_msg(input string s);
    for (int i = 0; i < 16; i++) begin
      if (i < s.len()) cur_msg[i] = s[i];
      else cur_msg[i] = 8'($urandom);
    end
  endtask

  // parse the character string directly; cycle numbers count enabled edges from the flag rise
  task automatic model();
    int p, ch, val;
    byte unsigned c;
    int sv [3];
    bit [2:0] sm;
    m_ok = 0; p = 1; sm = '0; sv = '{0, 0, 0};
    forever begin
      c  = cur_msg[p];
      ch = (c == "R") ? 0 : (c == "G") ? 1 : (c == "B") ? 2 : -1;
      if (ch < 0 || p == 15) begin m_cyc = p + 1; return; end
      p++;
      val = 0;
      for (int j = 0; j < 4; j++) begin
        c = cur_msg[p];
        if (c < "0" || c > "9" || p == 15) begin m_cyc = p + 1; return; end
        val = val * 10 + (c - "0");
        p++;
      end
      sv[ch] = (val > DUTY_MAX) ? DUTY_MAX : val;
      sm[ch] = 1'b1;
      c = cur_msg[p];
      if (c == "}") begin
        m_ok = 1; m_cyc = p + 1; m_v = sv; m_mask = sm;
        return;
      end
      if (c != "," || p == 15) begin m_cyc = p + 1; return; end
      p++;
    end
  endtask

  task automatic check_state(input string name);
    chk({name, "_duty_r"}, 32'(duty_r), exp_duty[0]);
    chk({name, "_duty_g"}, 32'(duty_g), exp_duty[1]);
    chk({name, "_duty_b"}, 32'(duty_b), exp_duty[2]);
`ifdef RX_DEC_ERR_CNT_EN
    chk({name, "_err_count"}, 32'(err_count), (exp_errs > 255) ? 255 : exp_errs);
`endif
  endtask

  task automatic run_msg(input bit toggle_en, input int drop_at, input string name);
    int en_idx, seen_at, drop_seen;
    bit seen, seen_err, was_en;
    clk_enable = 1'b1;
    valid_message_flag = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) valid_messege_out[8*(15-i) +: 8] = cur_msg[i];
    valid_message_flag = 1'b1;
    model();
    en_idx = -1; seen = 0; seen_at = -1; seen_err = 0; drop_seen = -1;
    for (int e = 0; e < 80 && !seen; e++) begin
      was_en = clk_enable;
      tick();
      if (was_en) begin
        en_idx++;
        if (drop_at > 0 && en_idx == 0) valid_message_flag = 1'b0;
        if (drop_at > 0 && en_idx == drop_at - 1) valid_message_flag = 1'b1;
        if (msg_dropped && drop_seen < 0) drop_seen = en_idx;
      end
      chk({name, "_busy"}, 32'(busy), (en_idx < m_cyc) ? 1 : 0);
      chk({name, "_exclusive"}, 32'(update_pulse & decode_err), 0);
      if (update_pulse || decode_err) begin
        seen = 1; seen_at = en_idx; seen_err = decode_err;
      end
      if (toggle_en) clk_enable = ~clk_enable;
    end
    clk_enable = 1'b1;
    chk({name, "_done"}, 32'(seen), 1);
    chk({name, "_is_err"}, 32'(seen_err), m_ok ? 0 : 1);
    chk({name, "_cycle"}, seen_at, m_cyc);
    if (m_ok) begin
      for (int c = 0; c < 3; c++) if (m_mask[c]) exp_duty[c] = m_v[c];
    end else begin
      exp_errs++;
    end
    if (drop_at > 0) begin
      chk({name, "_drop_cycle"}, drop_seen, drop_at);
      exp_errs++;
    end
    check_state(name);
    tick();
    chk({name, "_pulses_clear"}, {29'd0, update_pulse, decode_err, busy}, 0);
  endtask

  task automatic gen_random();
    string letters = "RGBRGBRGBX";
    string fillers = "5,}a";
    int p, nf, k;
    cur_msg[0] = "{";
    for (int i = 1; i < 16; i++) cur_msg[i] = 8'($urandom);
    p = 1;
    nf = $urandom_range(1, 3);
    for (int f = 0; f < nf && p < 16; f++) begin
      cur_msg[p] = letters[$urandom_range(0, 9)]; p++;
      k = $urandom_range(0, 3);
      for (int j = 0; j < 4 && p < 16; j++) begin
        if ($urandom_range(0, 24) == 0) cur_msg[p] = fillers[$urandom_range(0, 3)];
        else if (k == 0) cur_msg[p] = "9";
        else cur_msg[p] = 8'("0" + $urandom_range(0, 9));
        p++;
      end
      if (p < 16) begin
        if ($urandom_range(0, 14) == 0) cur_msg[p] = ";";
        else cur_msg[p] = (f == nf - 1) ? "}" : ",";
        p++;
      end
    end
  endtask

  initial begin
    bit stray;
    exp_duty = '{0, 0, 0};

    tick();
    tick();
    chk("reset_outputs", {25'd0, update_pulse, decode_err, msg_dropped, busy, 3'd0}, 0);
    check_state("reset");
    rst = 1'b0;
    clk_enable = 1'b1;

    load_msg("{R0500}");
    run_msg(0, -1, "t1");
    chk("t1_latency", m_cyc, 7);

    load_msg("{G9999,B0042}");
    run_msg(0, -1, "t2");
    chk("t2_latency", m_cyc, 13);

    load_msg("{X1234}");
    run_msg(0, -1, "t3");

    load_msg("{R0100}");
    run_msg(0, 3, "t4");

    load_msg("{B0007}");
    run_msg(1, -1, "t5");

    // reset in the middle of a message, applied with clk_enable low
    clk_enable = 1'b1;
    valid_message_flag = 1'b0;
    tick();
    load_msg("{R1111}");
    for (int i = 0; i < 16; i++) valid_messege_out[8*(15-i) +: 8] = cur_msg[i];
    valid_message_flag = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    clk_enable = 1'b0;
    tick();
    exp_duty = '{0, 0, 0};
    exp_errs = 0;
    chk("t6_reset_outputs", {28'd0, update_pulse, decode_err, msg_dropped, busy}, 0);
    check_state("t6_reset");
    rst = 1'b0;
    clk_enable = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (update_pulse || decode_err || busy) stray = 1;
    end
    chk("t6_no_stray_activity", 32'(stray), 0);
    load_msg("{R0123}");
    run_msg(0, -1, "t6_next");

    load_msg("{R1000,G1001}");
    run_msg(0, -1, "sat_edge");
    load_msg("{R0001,R0002}");
    run_msg(0, -1, "repeat_letter");
    load_msg("{R0000}");
    run_msg(0, -1, "zero");
    load_msg("{R1111,G2222,B34");
    run_msg(0, -1, "underflow");
    load_msg("{R12a4}");
    run_msg(0, -1, "bad_digit");
    load_msg("{G0300;");
    run_msg(0, -1, "bad_sep");

    for (int n = 0; n < 30; n++) begin
      gen_random();
      run_msg(n % 5 == 4, -1, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
